tick_pwm_gen: RTL

TICK_PWM_GEN -- requirements
Module: tick_pwm_gen

---
 rtl/tick_pwm_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/tick_pwm_gen.sv
// Tick-driven PWM generator with shadowed period/duty, applied at period boundaries.
// Define TICK_PWM_DONE_EN to add the one-cycle period_done pulse output.
module tick_pwm_gen #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_in,
   input  logic         en,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_period,
   input  logic [W-1:0] cfg_duty,
   output logic         pwm_out,
`ifdef TICK_PWM_DONE_EN
   output logic         period_done,
`endif
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_t;

   localparam logic [W-1:0] PER_RST  = '1;
   localparam logic [W-1:0] DUTY_RST = W'(1) << (W - 1);
   localparam logic [W-1:0] ONE      = W'(1);

   state_t       state;
   state_t       state_nx;
   logic [W-1:0] per_sh;
   logic [W-1:0] duty_sh;
   logic [W-1:0] per_act;
   logic [W-1:0] duty_act;
   logic [W-1:0] cnt;
   logic         pend;
   logic         cfg_hs;
   logic         bnd;
   logic         apply;

   assign cfg_ready = !pend;
   assign cfg_hs    = cfg_valid && !pend;
   assign bnd       = (state == RUN) && tick_in && (cnt == per_act);
   assign apply     = pend && ((state == LOAD) || bnd);
   assign busy      = (state != IDLE);
   assign pwm_out   = (state == RUN) && (cnt < duty_act);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (en) state_nx = LOAD;
         LOAD:    state_nx = en ? RUN : IDLE;
         RUN:     if (bnd && !en) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (state == LOAD) begin
         cnt <= '0;
      end else if ((state == RUN) && tick_in) begin
         cnt <= bnd ? '0 : cnt + ONE;
      end
   end

   // pend blocks a handshake, so apply and capture never share a cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         per_sh   <= PER_RST;
         duty_sh  <= DUTY_RST;
         per_act  <= PER_RST;
         duty_act <= DUTY_RST;
         pend     <= 1'b0;
      end else begin
         if (apply) begin
            per_act  <= per_sh;
            duty_act <= duty_sh;
            pend     <= 1'b0;
         end
         if (cfg_hs) begin
            per_sh  <= cfg_period;
            duty_sh <= cfg_duty;
            pend    <= 1'b1;
         end
      end
   end

`ifdef TICK_PWM_DONE_EN
   always_ff @(posedge clk) begin
      if (rst) period_done <= 1'b0;
      else     period_done <= bnd;
   end
`endif

endmodule
